// File: rtl/eq_3.sv
// eq_3: four-input Boolean evaluator for equation set 3.
// The combinational output o is looked up from TRUTH_TABLE using {a,b,c,d}.
// The clocked section keeps a registered copy of the last sampled result and
// index. It also records which of the 16 input combinations have been
// sampled, and how many distinct sampled combinations evaluated to 1.
module eq_3 #(
  parameter logic [15:0] TRUTH_TABLE = 16'h4F62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        sample_en,
  input  logic        clr,
  output logic        o,
  output logic        o_q,
  output logic [3:0]  idx_q,
  output logic [15:0] seen,
  output logic        all_seen,
  output logic [4:0]  ones_cnt
);

  // Input index, with a as the MSB.
  logic [3:0] idx;
  assign idx = {a, b, c, d};

  // Primary function: a pure table lookup, valid with or without a clock.
  assign o = TRUTH_TABLE[idx];

  logic        o_d;
  logic [3:0]  idx_d;
  logic [15:0] seen_d;
  logic [15:0] seen_q;
  logic [4:0]  ones_cnt_d;
  logic [4:0]  ones_cnt_q;

  // Next-state logic: clear beats sample, and idle edges hold every register.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can leave one
    // unassigned and infer a latch.
    o_d        = o_q;
    idx_d      = idx_q;
    seen_d     = seen_q;
    ones_cnt_d = ones_cnt_q;
    if (clr) begin
      o_d        = 1'b0;
      idx_d      = 4'd0;
      seen_d     = 16'd0;
      ones_cnt_d = 5'd0;
    end else if (sample_en) begin
      o_d         = o;
      idx_d       = idx;
      seen_d[idx] = 1'b1;
      // Only the first sample of a 1-valued index is counted.
      if (!seen_q[idx] && o) begin
        ones_cnt_d = ones_cnt_q + 5'd1;
      end
    end
  end

  // State registers; reset discards all coverage state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q        <= 1'b0;
      idx_q      <= 4'd0;
      seen_q     <= 16'd0;
      ones_cnt_q <= 5'd0;
    end else begin
      // NOTE: non-blocking assignments here let every flop sample the values
      // from before the edge, whatever order the statements are in.
      o_q        <= o_d;
      idx_q      <= idx_d;
      seen_q     <= seen_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  assign seen     = seen_q;
  assign ones_cnt = ones_cnt_q;
  assign all_seen = (seen_q == 16'hFFFF);

endmodule

// File: tb/tb_eq_3.sv
// tb_eq_3: directed testbench for eq_3. It has one task per scenario, and
// each task checks its expected values inline.
module tb_eq_3;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        c = 1'b0;
  logic        d = 1'b0;
  logic        sample_en = 1'b0;
  logic        clr = 1'b0;
  logic        o;
  logic        o_q;
  logic [3:0]  idx_q;
  logic [15:0] seen;
  logic        all_seen;
  logic [4:0]  ones_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected o for each index 0..15, entered by hand from the equation.
  logic [15:0] exp_o = 16'b0100_1111_0110_0010;
  // Running count of distinct 1-valued indices after sampling 0..i in order.
  int exp_cnt[16] = '{0, 1, 1, 1, 1, 2, 3, 3, 4, 5, 6, 7, 7, 7, 8, 8};

  eq_3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .sample_en(sample_en),
    .clr      (clr),
    .o        (o),
    .o_q      (o_q),
    .idx_q    (idx_q),
    .seen     (seen),
    .all_seen (all_seen),
    .ones_cnt (ones_cnt)
  );

  // Gated clock, so the combinational sweep can run with no clock activity.
  always #5 if (clk_en) clk = ~clk;

  task automatic apply(input logic [3:0] idx);
    {a, b, c, d} = idx;
  endtask

  // Drive one index with sample_en high through a rising edge, then sample #1 later.
  task automatic sample(input logic [3:0] idx);
    apply(idx);
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_comb_sweep();
    for (int i = 0; i < 16; i++) begin
      apply(4'(i));
      #1;
      n_checks++;
      if (o !== exp_o[i]) begin
        n_fail++;
        $display("FAIL comb_sweep idx=%0d o=%b expected=%b", i, o, exp_o[i]);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({o_q, idx_q, seen, all_seen, ones_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state o_q=%b idx_q=%h seen=%h all_seen=%b ones_cnt=%0d expected all 0",
               o_q, idx_q, seen, all_seen, ones_cnt);
    end
  endtask

  task automatic test_clocked_sweep();
    for (int i = 0; i < 16; i++) begin
      sample(4'(i));
      n_checks++;
      if (ones_cnt !== 5'(exp_cnt[i]) || idx_q !== 4'(i) || o_q !== exp_o[i]) begin
        n_fail++;
        $display("FAIL clocked_step idx=%0d ones_cnt=%0d idx_q=%0d o_q=%b expected %0d %0d %b",
                 i, ones_cnt, idx_q, o_q, exp_cnt[i], i, exp_o[i]);
      end
    end
    n_checks++;
    if (all_seen !== 1'b1 || seen !== 16'hFFFF || ones_cnt !== 5'd8 ||
        idx_q !== 4'hF || o_q !== 1'b0) begin
      n_fail++;
      $display("FAIL clocked_sweep all_seen=%b seen=%h ones_cnt=%0d idx_q=%h o_q=%b expected 1 ffff 8 f 0",
               all_seen, seen, ones_cnt, idx_q, o_q);
    end
  endtask

  task automatic test_hold();
    apply(4'd3);
    sample_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (seen !== 16'hFFFF || ones_cnt !== 5'd8 || idx_q !== 4'hF || o_q !== 1'b0) begin
      n_fail++;
      $display("FAIL hold seen=%h ones_cnt=%0d idx_q=%h o_q=%b expected ffff 8 f 0",
               seen, ones_cnt, idx_q, o_q);
    end
  endtask

  task automatic test_duplicate();
    do_clear();
    for (int k = 0; k < 3; k++) begin
      sample(4'd9);
      n_checks++;
      if (ones_cnt !== 5'd1 || seen !== 16'h0200 || idx_q !== 4'd9 || o_q !== 1'b1 ||
          all_seen !== 1'b0) begin
        n_fail++;
        $display("FAIL duplicate pass=%0d ones_cnt=%0d seen=%h idx_q=%0d o_q=%b all_seen=%b expected 1 0200 9 1 0",
                 k, ones_cnt, seen, idx_q, o_q, all_seen);
      end
    end
  endtask

  task automatic test_clear_priority();
    sample(4'd6);
    n_checks++;
    if (ones_cnt !== 5'd2 || seen !== 16'h0240) begin
      n_fail++;
      $display("FAIL pre_clear ones_cnt=%0d seen=%h expected 2 0240", ones_cnt, seen);
    end
    apply(4'd5);
    clr = 1'b1;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    sample_en = 1'b0;
    n_checks++;
    if (seen !== 16'd0 || ones_cnt !== 5'd0 || o_q !== 1'b0 || idx_q !== 4'd0) begin
      n_fail++;
      $display("FAIL clear_priority seen=%h ones_cnt=%0d o_q=%b idx_q=%0d expected 0 0 0 0",
               seen, ones_cnt, o_q, idx_q);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) sample(4'(i));
    n_checks++;
    if (seen !== 16'h00FF || ones_cnt !== 5'd3 || idx_q !== 4'd7 || o_q !== 1'b0) begin
      n_fail++;
      $display("FAIL half_sweep seen=%h ones_cnt=%0d idx_q=%0d o_q=%b expected 00ff 3 7 0",
               seen, ones_cnt, idx_q, o_q);
    end
    // Assert the reset between clock edges, well away from the rising edge.
    apply(4'd10);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (seen !== 16'd0 || ones_cnt !== 5'd0 || idx_q !== 4'd0 || o_q !== 1'b0 ||
        all_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset seen=%h ones_cnt=%0d idx_q=%0d o_q=%b all_seen=%b expected all 0",
               seen, ones_cnt, idx_q, o_q, all_seen);
    end
    n_checks++;
    if (o !== 1'b1) begin
      n_fail++;
      $display("FAIL o_in_reset idx=10 o=%b expected=1", o);
    end
    apply(4'd12);
    #1;
    n_checks++;
    if (o !== 1'b0) begin
      n_fail++;
      $display("FAIL o_in_reset idx=12 o=%b expected=0", o);
    end
    // Release mid-cycle; the next sampled edge behaves normally.
    @(negedge clk);
    rst_n = 1'b1;
    sample(4'd14);
    n_checks++;
    if (seen !== 16'h4000 || ones_cnt !== 5'd1 || idx_q !== 4'd14 || o_q !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset seen=%h ones_cnt=%0d idx_q=%0d o_q=%b expected 4000 1 14 1",
               seen, ones_cnt, idx_q, o_q);
    end
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    test_comb_sweep();
    test_reset();
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_clocked_sweep();
    test_hold();
    test_duplicate();
    test_clear_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_3.md
# eq_3

Four-input single-output Boolean evaluator for equation set 3, with a registered copy of the result and minterm-coverage tracking. The combinational output `o` is the primary function and is valid immediately after any input change; the clocked section provides a pipelined result and a record of which of the 16 input combinations have been sampled. It sits as a leaf block in the combinational-equation test group and may be driven by an exhaustive sweep or a free-running source.

## Interface
- `TRUTH_TABLE`, default 16'h4F62: bit i is the value of `o` for input index i = {a,b,c,d}, with a as MSB.
- `clk`  in  1  rising-edge clock for all registered logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  1  equation input, index bit 3 (MSB).
- `b`  in  1  equation input, index bit 2.
- `c`  in  1  equation input, index bit 1.
- `d`  in  1  equation input, index bit 0 (LSB).
- `sample_en`  in  1  when 1 at a clock edge, capture the current inputs and result.
- `clr`  in  1  synchronous clear of coverage state; has priority over `sample_en`.
- `o`  out  1  combinational result: `TRUTH_TABLE[{a,b,c,d}]`.
- `o_q`  out  1  registered `o` from the last sampled edge.
- `idx_q`  out  4  registered index {a,b,c,d} from the last sampled edge.
- `seen`  out  16  bit i set once index i has been sampled.
- `all_seen`  out  1  1 when `seen` == 16'hFFFF.
- `ones_cnt`  out  5  number of distinct sampled indices whose result was 1 (range 0..8 with the default table).

## Operation
- With the default table, `o` = (a & ~b) | (b & c & ~d) | (~a & ~c & d).
- The indices with `o`=1 are 1, 5, 6, 8, 9, 10, 11 and 14. All other indices give `o`=0.
- `o` is purely combinational and independent of `clk`, `rst_n`, `sample_en` and `clr`. It must be valid whether or not the block is clocked.
- On a sampled edge (`sample_en`=1, `clr`=0):
  - `o_q` <= `o`.
  - `idx_q` <= {a,b,c,d}.
  - `seen[idx]` <= 1.
  - If `seen[idx]` was 0 and `o`=1, `ones_cnt` increments. Repeat samples of the same index never increment it.
- On a clear edge (`clr`=1): `seen`, `ones_cnt`, `o_q` and `idx_q` all go to 0, regardless of `sample_en`.
- On an edge with `sample_en`=0 and `clr`=0: all registers hold.
- `all_seen` is combinational from `seen`.
- X/Z on any input: no requirement beyond normal simulator propagation.

## Timing
- `o`: zero-cycle combinational path from `a`, `b`, `c`, `d`. It must settle within any stimulus step of at least 1 time unit.
- Registered outputs: 1-cycle latency from the sampled edge.
- Reset: `rst_n`=0 immediately forces `o_q`=0, `idx_q`=0, `seen`=0 and `ones_cnt`=0, and therefore `all_seen`=0.
  - `o` continues to follow its inputs during reset.
  - Release of `rst_n` is synchronised by the integrator; the first sampled edge after release behaves normally.
- Reset asserted mid-sweep discards all coverage state. No partial state is retained.
- `ones_cnt` cannot overflow: its maximum is the population count of `TRUTH_TABLE`, which is at most 16.

## Test plan
- Exhaustive combinational sweep, no clock toggling: apply indices 0..15 in order at 1-time-unit steps. `o` must read 0,1,0,0,0,1,1,0,1,1,1,1,0,0,1,0.
- Clocked sweep: from reset, sample indices 0..15 with `sample_en`=1. Result: `all_seen`=1, `ones_cnt`=8, `idx_q`=4'hF, `o_q`=0.
- Duplicate sampling: sample index 9 three times. Result: `ones_cnt`=1, `seen`=16'h0200.
- Clear priority: `clr`=1 and `sample_en`=1 on the same edge with index 5 applied. Result: `seen`=0, `ones_cnt`=0, `o_q`=0.
- Async reset mid-sweep: sample indices 0..7, then pulse `rst_n` low between clock edges. All registered outputs go to 0 immediately, while `o` still tracks the applied inputs.
